// File: rtl/pixel_stream_buffer_if.sv
// Upstream pixel stream handshake: the producer drives data/valid, the buffer returns ready.
interface pixel_stream_buffer_if #(
    parameter int PIXEL_W = 6
);
    logic [PIXEL_W-1:0] in_data;
    logic               in_valid;
    logic               in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pixel_stream_buffer.sv
// Pixel FIFO between a bursty upstream and a display timing generator.
// Each popped pixel is held for H_SCALE active clocks; blanking drives black.
module pixel_stream_buffer #(
    parameter int DEPTH   = 8,
    parameter int PIXEL_W = 6,
    parameter int H_SCALE = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    pixel_stream_buffer_if.slave      up,
    input  logic                      horizontal_blank,
    input  logic                      vertical_blank,
    input  logic                      new_frame,
    output logic [PIXEL_W-1:0]        rgb_out,
    output logic                      frame_restart,
    output logic                      underflow,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;

    logic [PIXEL_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [PW-1:0]      phase;
    logic               active, empty, last_phase, push, pop;

    assign active     = !horizontal_blank && !vertical_blank;
    assign empty      = (level == '0);
    assign last_phase = (phase == PW'(H_SCALE - 1));
    // ready is forced low in reset and during the frame-restart cycle
    assign up.in_ready = !rst && (level < (AW + 1)'(DEPTH)) && !new_frame;
    assign push        = up.in_valid && up.in_ready;
    // an empty FIFO never pops, so a same-cycle push into empty is kept
    assign pop         = active && last_phase && !empty && !new_frame;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= up.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            phase         <= '0;
            rgb_out       <= '0;
            frame_restart <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            frame_restart <= new_frame;
            rgb_out       <= (active && !empty) ? mem[rd_ptr] : '0;
            if (new_frame) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                phase     <= '0;
                underflow <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
                phase <= (active && !last_phase) ? phase + 1'b1 : '0;
                if (active && empty) underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pixel_stream_buffer.sv
// Directed bench: default-parameter buffer plus an H_SCALE=1 instance.
module tb_pixel_stream_buffer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hb = 1'b1, vb = 1'b1, nf = 1'b0;
    logic       hb2 = 1'b1, vb2 = 1'b1, nf2 = 1'b0;
    logic [5:0] rgb, rgb2;
    logic       fr, fr2, uf, uf2;
    logic [3:0] lvl, lvl2;
    int         checks = 0;
    int         failures = 0;

    pixel_stream_buffer_if #(.PIXEL_W(6)) s1 ();
    pixel_stream_buffer_if #(.PIXEL_W(6)) s2 ();

    pixel_stream_buffer #(.DEPTH(8), .PIXEL_W(6), .H_SCALE(2)) dut (
        .clk(clk), .rst(rst), .up(s1.slave),
        .horizontal_blank(hb), .vertical_blank(vb), .new_frame(nf),
        .rgb_out(rgb), .frame_restart(fr), .underflow(uf), .level(lvl));

    pixel_stream_buffer #(.DEPTH(8), .PIXEL_W(6), .H_SCALE(1)) dut2 (
        .clk(clk), .rst(rst), .up(s2.slave),
        .horizontal_blank(hb2), .vertical_blank(vb2), .new_frame(nf2),
        .rgb_out(rgb2), .frame_restart(fr2), .underflow(uf2), .level(lvl2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        s1.in_data = '0; s1.in_valid = 1'b0;
        s2.in_data = '0; s2.in_valid = 1'b0;
        #1;
        chk("rst_level", lvl, 0);
        chk("rst_ready", s1.in_ready, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_uf", uf, 0);
        chk("rst_fr", fr, 0);
        tick; tick;
        rst = 1'b0;
        tick;
        chk("post_rst_ready", s1.in_ready, 1);

        // fill during blanking
        for (int i = 1; i <= 8; i++) begin
            s1.in_valid = 1'b1; s1.in_data = 6'(i);
            tick;
        end
        chk("full_level", lvl, 8);
        chk("full_ready", s1.in_ready, 0);
        chk("full_rgb", rgb, 0);
        s1.in_data = 6'h3F;
        tick;
        chk("full_no_push", lvl, 8);
        s1.in_valid = 1'b0;

        // four active cycles, each pixel shown twice
        hb = 1'b0; vb = 1'b0;
        tick; chk("act_rgb0", rgb, 6'h01);
        tick; chk("act_rgb1", rgb, 6'h01);
        tick; chk("act_rgb2", rgb, 6'h02);
        tick; chk("act_rgb3", rgb, 6'h02);
        hb = 1'b1;
        chk("act_level", lvl, 6);
        tick; chk("blank_black", rgb, 0);

        nf = 1'b1;
        tick;
        chk("nf_level", lvl, 0);
        chk("nf_fr", fr, 1);
        nf = 1'b0;
        tick;
        chk("nf_fr_clear", fr, 0);

        // underflow on empty FIFO
        hb = 1'b0;
        tick; chk("uf_rgb0", rgb, 0); chk("uf_set", uf, 1);
        tick; chk("uf_rgb1", rgb, 0);
        tick; chk("uf_rgb2", rgb, 0);
        hb = 1'b1;
        tick; chk("uf_sticky", uf, 1);

        for (int i = 0; i < 5; i++) begin
            s1.in_valid = 1'b1; s1.in_data = 6'(8'h11 + i);
            tick;
        end
        chk("pre_nf_level", lvl, 5);
        chk("pre_nf_uf", uf, 1);
        s1.in_data = 6'h3F; nf = 1'b1;
        #1 chk("nf_block_ready", s1.in_ready, 0);
        tick;
        chk("nf2_level", lvl, 0);
        chk("nf2_uf", uf, 0);
        chk("nf2_fr", fr, 1);
        nf = 1'b0; s1.in_valid = 1'b0;
        tick;
        chk("nf2_fr_once", fr, 0);
        chk("nf2_discard", lvl, 0);

        // new_frame during an underflow condition: clear wins
        hb = 1'b0; nf = 1'b1;
        tick;
        chk("nf_uf_clear", uf, 0);
        nf = 1'b0; hb = 1'b1;
        tick;
        chk("nf_uf_hold", uf, 0);

        // H_SCALE=1 instance: simultaneous push and pop
        s2.in_valid = 1'b1; s2.in_data = 6'h07;
        tick;
        chk("h1_level1", lvl2, 1);
        hb2 = 1'b0; vb2 = 1'b0; s2.in_data = 6'h2A;
        tick;
        chk("h1_old_head", rgb2, 6'h07);
        chk("h1_level_same", lvl2, 1);
        s2.in_valid = 1'b0;
        tick;
        chk("h1_new_head", rgb2, 6'h2A);
        chk("h1_level0", lvl2, 0);
        s2.in_valid = 1'b1; s2.in_data = 6'h15;
        tick;
        chk("h1_empty_push_rgb", rgb2, 0);
        chk("h1_empty_push_lvl", lvl2, 1);
        chk("h1_uf", uf2, 1);
        s2.in_valid = 1'b0;
        tick;
        chk("h1_push_shown", rgb2, 6'h15);
        hb2 = 1'b1;
        tick;
        chk("h1_blank", rgb2, 0);

        // asynchronous reset mid-line
        for (int i = 0; i < 4; i++) begin
            s1.in_valid = 1'b1; s1.in_data = 6'(8'h21 + i);
            tick;
        end
        s1.in_valid = 1'b0;
        chk("ar_level4", lvl, 4);
        hb = 1'b0; vb = 1'b0;
        tick; tick;
        chk("ar_rgb_live", rgb, 6'h21);
        #2 rst = 1'b1;
        #1;
        chk("ar_rgb0", rgb, 0);
        chk("ar_level0", lvl, 0);
        chk("ar_ready0", s1.in_ready, 0);
        tick;
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pixel_stream_buffer.md
PIXEL_STREAM_BUFFER -- requirements
Module: pixel_stream_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of two, 4..16).
REQ-002 Parameter PIXEL_W, default 6, pixel width (RGB222).
REQ-003 Parameter H_SCALE, default 2, output clocks per popped pixel (1 or 2).
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  PIXEL_W  upstream pixel.
REQ-007 in_valid  input  1  upstream pixel present.
REQ-008 in_ready  output  1  buffer accepts pixel this cycle.
REQ-009 horizontal_blank  input  1  high outside active columns.
REQ-010 vertical_blank  input  1  high outside active rows.
REQ-011 new_frame  input  1  one-cycle pulse at frame start.
REQ-012 rgb_out  output  PIXEL_W  registered pixel to DAC pins.
REQ-013 frame_restart  output  1  registered one-cycle pulse telling upstream to restart at pixel 0.
REQ-014 underflow  output  1  sticky: active pixel needed while FIFO empty.
REQ-015 level  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Push occurs when in_valid && in_ready; in_ready = (level < DEPTH) && !new_frame.
REQ-017 active = !horizontal_blank && !vertical_blank.
REQ-018 Phase counter (0..H_SCALE-1) advances each active cycle, resets to 0 on any non-active cycle.
REQ-019 Pop request occurs on an active cycle with phase == H_SCALE-1.
REQ-020 rgb_out registers the FIFO head on every active cycle while level > 0; the head advances only on pops, so each pixel is shown H_SCALE consecutive cycles; rgb_out latency from active cycle is 1 clock.
REQ-021 rgb_out is registered to 0 on every non-active cycle (blanking black).
REQ-022 Active cycle with level == 0: rgb_out registers 0, no pop, underflow set to 1 next cycle.
REQ-023 Simultaneous push and pop: both occur, level unchanged; with level == 0 a same-cycle push is not popped that cycle.
REQ-024 Pointers wrap modulo DEPTH; level never exceeds DEPTH or drops below 0.
REQ-025 new_frame: read/write pointers and level cleared, phase cleared, underflow cleared, next cycle frame_restart = 1 for exactly one cycle; any push in that cycle is blocked.
REQ-026 new_frame coinciding with an underflow condition: clear wins, underflow stays 0.
REQ-027 frame_restart is 0 in all other cycles.

Reset
REQ-028 While rst high: level = 0, pointers = 0, phase = 0, rgb_out = 0, frame_restart = 0, underflow = 0, in_ready = 0.
REQ-029 First edge after rst deasserts: in_ready = 1 (empty FIFO); FIFO contents are don't-care.
REQ-030 rst asserted mid-line takes effect immediately (asynchronous), discarding buffered pixels.

Verification
REQ-031 Reset, push 0x01..0x08 (DEPTH 8) with blanking high -> level = 8, in_ready = 0, rgb_out = 0.
REQ-032 From full, 4 active cycles, H_SCALE 2 -> rgb_out 0x01,0x01,0x02,0x02 starting 1 clock after first active cycle; level = 6.
REQ-033 Empty FIFO, 3 active cycles -> rgb_out = 0 each, underflow = 1 from the cycle after the first, held through blanking.
REQ-034 underflow = 1, level = 5, pulse new_frame with in_valid high -> level = 0 next cycle, underflow = 0, frame_restart = 1 for one cycle, pushed pixel discarded.
REQ-035 H_SCALE 1, level = 1, active cycle with simultaneous push of 0x2A -> rgb_out = old head, level = 1, next active cycle rgb_out = 0x2A.
REQ-036 Assert rst mid-active line with level = 4 -> rgb_out = 0 and level = 0 without waiting for a clock edge.
